vector_checker: RTL and testbench

Synthesizable, parametrised vector-table engine that drives stimulus into a combinational unit under test and compares the response against an expected value, one vector per pass. It replaces hand-written, simulation-only clock/readmem benches for small lab blocks such as decoders and muxes. It can run on the board next to the unit under test. The vector table is loaded through a write port, and reporting is cycle-accurate.

---
 rtl/vector_checker_pkg.sv | 26 ++
 rtl/vec_table_ram.sv | 24 ++
 rtl/vector_checker.sv | 145 ++++++++++++++
 tb/tb_vector_checker.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_checker_pkg.sv
// Shared types and constant helpers for the vector_checker engine.
package vector_checker_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StCheck,
        StDone
    } state_e;

    localparam int unsigned MaxVecW = 64;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    // All-ones pattern of width w, right-aligned; callers cast to their own width.
    function automatic logic [MaxVecW-1:0] sentinel(input int unsigned w);
        return {MaxVecW{1'b1}} >> (MaxVecW - w);
    endfunction

endpackage

// File: rtl/vec_table_ram.sv
// Vector table storage: synchronous write, combinational read, no reset so
// contents survive a mid-run reset.
module vec_table_ram #(
    parameter int unsigned Depth = 16,
    parameter int unsigned AddrW = 4,
    parameter int unsigned VecW  = 7
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [VecW-1:0]  wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [VecW-1:0]  rdata_o
);

    logic [VecW-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/vector_checker.sv
// Vector-table engine: applies stored stimulus to a combinational unit under
// test, waits SETTLE cycles, compares the response and reports mismatches.
module vector_checker
    import vector_checker_pkg::*;
#(
    parameter int unsigned IN_W   = 3,
    parameter int unsigned OUT_W  = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERR_W  = 8,
    localparam int unsigned VEC_W  = IN_W + OUT_W,
    localparam int unsigned ADDR_W = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [VEC_W-1:0]  ld_data,
    input  logic              start,
    input  logic              stop_on_err,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              err_pulse,
    output logic [ADDR_W-1:0] err_index,
    output logic [OUT_W-1:0]  err_got,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W:0]   vec_count
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? clog2(SETTLE) : 1;
    localparam logic [VEC_W-1:0]  SENTINEL    = VEC_W'(sentinel(VEC_W));
    localparam logic [CNT_W-1:0]  SETTLE_INIT = CNT_W'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [OUT_W-1:0]  exp_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              stop_q;
    logic [VEC_W-1:0]  entry0_q;

    logic              idle_like;
    logic [ADDR_W-1:0] rd_addr;
    logic [VEC_W-1:0]  rd_data;
    logic [VEC_W-1:0]  cur_vec;
    logic              mismatch;

    assign idle_like = (state_q == StIdle) || (state_q == StDone);
    assign rd_addr   = idle_like ? '0 : idx_q;
    // Entry 0 is snapshotted at start so a same-cycle write to it is seen only by later runs.
    assign cur_vec   = (idx_q == '0) ? entry0_q : rd_data;
    assign mismatch  = (dut_out != exp_q);

    vec_table_ram #(
        .Depth (DEPTH),
        .AddrW (ADDR_W),
        .VecW  (VEC_W)
    ) u_table (
        .clk_i   (clk),
        .we_i    (ld_we && idle_like),
        .waddr_i (ld_addr),
        .wdata_i (ld_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            exp_q     <= '0;
            cnt_q     <= '0;
            stop_q    <= 1'b0;
            entry0_q  <= '0;
            dut_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_pulse <= 1'b0;
            err_index <= '0;
            err_got   <= '0;
            err_count <= '0;
            vec_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q   <= StApply;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_index <= '0;
                        err_got   <= '0;
                        err_count <= '0;
                        vec_count <= '0;
                        idx_q     <= '0;
                        stop_q    <= stop_on_err;
                        entry0_q  <= rd_data;
                    end
                end
                StApply: begin
                    if (cur_vec == SENTINEL) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_count == '0);
                    end else begin
                        dut_in  <= cur_vec[VEC_W-1 -: IN_W];
                        exp_q   <= cur_vec[OUT_W-1:0];
                        cnt_q   <= SETTLE_INIT;
                        state_q <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_q == '0) state_q <= StCheck;
                    else cnt_q <= cnt_q - 1'b1;
                end
                StCheck: begin
                    vec_count <= vec_count + 1'b1;
                    if (mismatch) begin
                        err_pulse <= 1'b1;
                        err_index <= idx_q;
                        err_got   <= dut_out;
                        if (err_count != '1) err_count <= err_count + 1'b1;
                    end
                    if (idx_q == LAST_IDX || (stop_q && mismatch)) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= !mismatch && (err_count == '0);
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StApply;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_checker.sv
// Scoreboard bench: a 2-to-4 decoder with enable is the unit under test; a
// table-level model predicts error events and run results per start.
module tb_vector_checker;

    localparam int unsigned IN_W    = 3;
    localparam int unsigned OUT_W   = 4;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned SETTLE  = 2;
    localparam int unsigned ERR_W   = 2;
    localparam int unsigned VEC_W   = IN_W + OUT_W;
    localparam int unsigned ADDR_W  = 4;
    localparam int          ERR_MAX = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              reset, ld_we, start, stop_on_err;
    logic [ADDR_W-1:0] ld_addr;
    logic [VEC_W-1:0]  ld_data;
    logic [IN_W-1:0]   dut_in;
    logic [OUT_W-1:0]  dut_out;
    logic              busy, done, pass, err_pulse;
    logic [ADDR_W-1:0] err_index;
    logic [OUT_W-1:0]  err_got;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W:0]   vec_count;

    typedef struct {
        int               idx;
        logic [OUT_W-1:0] got;
    } err_ev_t;

    typedef struct {
        int vec;
        int errc;
        int pass;
        int done_cyc;
    } res_t;

    err_ev_t          err_q[$];
    res_t             res_q[$];
    logic [VEC_W-1:0] mtab [DEPTH];
    int               cyc = 0;
    int               total = 0;
    int               bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] s);
        logic [OUT_W-1:0] one;
        one = 4'b0001;
        return s[2] ? (one << s[1:0]) : 4'b0000;
    endfunction

    assign dut_out = decode(dut_in);

    vector_checker #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE),
        .ERR_W  (ERR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .start       (start),
        .stop_on_err (stop_on_err),
        .dut_in      (dut_in),
        .dut_out     (dut_out),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_pulse   (err_pulse),
        .err_index   (err_index),
        .err_got     (err_got),
        .err_count   (err_count),
        .vec_count   (vec_count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [VEC_W-1:0] mkvec(input logic [IN_W-1:0] s, input bit good);
        logic [OUT_W-1:0] e;
        e = decode(s);
        if (!good) e = e ^ 4'b0101;
        return {s, e};
    endfunction

    // Walk the table as the engine is meant to and queue what it should report.
    task automatic model_push(input bit stop, input int start_cyc);
        int n;
        int errs;
        bit hit_sent;
        n = 0;
        errs = 0;
        hit_sent = 0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [OUT_W-1:0] got;
            if (mtab[i] == {VEC_W{1'b1}}) begin
                hit_sent = 1;
                break;
            end
            got = decode(mtab[i][VEC_W-1 -: IN_W]);
            n++;
            if (got != mtab[i][OUT_W-1:0]) begin
                errs++;
                err_q.push_back('{idx: i, got: got});
                if (stop) break;
            end
        end
        res_q.push_back('{vec: n, errc: (errs > ERR_MAX) ? ERR_MAX : errs,
                          pass: (errs == 0) ? 1 : 0,
                          done_cyc: start_cyc + n * (SETTLE + 2) + (hit_sent ? 1 : 0)});
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [VEC_W-1:0] d);
        @(negedge clk);
        ld_we = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
        mtab[a] = d;
    endtask

    task automatic kick(input bit stop, input bit do_wr, input logic [ADDR_W-1:0] wa,
                        input logic [VEC_W-1:0] wd);
        @(negedge clk);
        model_push(stop, cyc + 1);
        stop_on_err = stop;
        start = 1'b1;
        if (do_wr) begin
            ld_we = 1'b1;
            ld_addr = wa;
            ld_data = wd;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        ld_we = 1'b0;
        if (do_wr) mtab[wa] = wd;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: done=%b required 1", done);
            err_q.delete();
            res_q.delete();
        end
    endtask

    task automatic run(input bit stop);
        kick(stop, 1'b0, '0, '0);
        wait_done();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_dut_in"}, dut_in, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err_pulse"}, err_pulse, 0);
        check({tag, "_err_index"}, err_index, 0);
        check({tag, "_err_got"}, err_got, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_vec_count"}, vec_count, 0);
    endtask

    // Monitor: pops expectations whenever the DUT reports an error or finishes.
    initial begin
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                done_prev = 1'b0;
            end else begin
                if (err_pulse) begin
                    if (err_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL err_pulse_unexpected: index %0d, none required", err_index);
                    end else begin
                        err_ev_t e;
                        e = err_q.pop_front();
                        check("err_index", err_index, e.idx);
                        check("err_got", err_got, e.got);
                    end
                end
                if (done && !done_prev) begin
                    if (res_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL done_unexpected: done=1 with no run outstanding");
                    end else begin
                        res_t r;
                        r = res_q.pop_front();
                        check("vec_count", vec_count, r.vec);
                        check("err_count", err_count, r.errc);
                        check("pass", pass, r.pass);
                        check("done_cycle", cyc, r.done_cyc);
                        check("busy_at_done", busy, 0);
                        check("missing_err_pulses", err_q.size(), 0);
                        err_q.delete();
                    end
                end
                done_prev = done;
            end
        end
    end

    initial begin
        reset = 1'b1;
        ld_we = 1'b0;
        start = 1'b0;
        stop_on_err = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        reset = 1'b0;

        // Reference: 8 correct vectors then sentinel.
        for (int i = 0; i < 8; i++) wr(ADDR_W'(i), mkvec(IN_W'(i), 1'b1));
        wr(4'd8, {VEC_W{1'b1}});
        run(1'b0);

        // Two bad expected values, without and with stop-on-error.
        wr(4'd2, mkvec(3'd2, 1'b0));
        wr(4'd5, mkvec(3'd5, 1'b0));
        run(1'b0);
        run(1'b1);

        // Sentinel at entry 0.
        wr(4'd0, {VEC_W{1'b1}});
        run(1'b0);
        wr(4'd0, mkvec(3'd0, 1'b1));

        // Full table, no sentinel.
        for (int i = 8; i < 16; i++) wr(ADDR_W'(i), mkvec(IN_W'(i), 1'b1));
        run(1'b0);

        // Five mismatches saturate the 2-bit counter.
        wr(4'd9, mkvec(3'd1, 1'b0));
        wr(4'd11, mkvec(3'd3, 1'b0));
        wr(4'd13, mkvec(3'd5, 1'b0));
        run(1'b0);

        // Reset during SETTLE_W of vector 4, then rerun with the table intact.
        kick(1'b0, 1'b0, '0, '0);
        repeat (4 * (SETTLE + 2) + 1) @(posedge clk);
        @(negedge clk);
        check("dut_in_vec4", dut_in, mtab[4][VEC_W-1 -: IN_W]);
        check("busy_vec4", busy, 1);
        reset = 1'b1;
        err_q.delete();
        res_q.delete();
        @(negedge clk);
        check_reset("midrun");
        reset = 1'b0;
        run(1'b0);

        // Write and start while busy are both dropped.
        kick(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        ld_we = 1'b1;
        ld_addr = 4'd3;
        ld_data = mkvec(3'd3, 1'b0);
        start = 1'b1;
        @(negedge clk);
        ld_we = 1'b0;
        start = 1'b0;
        wait_done();

        // Same-cycle write to entry 0 and start: this run sees the old entry.
        kick(1'b0, 1'b1, 4'd0, {VEC_W{1'b1}});
        wait_done();
        run(1'b0);
        wr(4'd0, mkvec(3'd0, 1'b1));

        // Random tables.
        for (int t = 0; t < 20; t++) begin
            int sp;
            sp = $urandom_range(16);
            for (int i = 0; i < DEPTH; i++) begin
                if (i == sp) wr(ADDR_W'(i), {VEC_W{1'b1}});
                else wr(ADDR_W'(i), mkvec(IN_W'($urandom), $urandom_range(3) != 0));
            end
            run(1'($urandom_range(1)));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
